vc_wb_buffer: RTL and testbench

VC_WB_BUFFER -- requirements
Module: vc_wb_buffer

---
 rtl/vc_types_pkg.sv | 13 +
 rtl/vc_wb_fifo.sv | 101 ++++++++++
 rtl/vc_wb_buffer.sv | 165 ++++++++++++++++
 tb/tb_vc_wb_buffer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_types_pkg.sv
// Shared types and default widths for the victim-cache writeback buffer.
package vc_types_pkg;

  // Writeback engine: idle, or holding a write request to physical memory.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wb_state_t;

  localparam int unsigned DEF_S_LINE = 256;
  localparam int unsigned DEF_S_ADDR = 32;

endpackage

// File: rtl/vc_wb_fifo.sv
// Storage for pending dirty lines: circular FIFO with per-entry read access
// so the owner can probe every occupied slot.
module vc_wb_fifo
  import vc_types_pkg::*;
#(
  parameter int unsigned s_line = DEF_S_LINE,
  parameter int unsigned s_addr = DEF_S_ADDR,
  parameter int unsigned depth  = 4,
  localparam int unsigned ptr_w = $clog2(depth),
  localparam int unsigned cnt_w = ptr_w + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [s_addr-1:0] push_addr_i,
  input  logic [s_line-1:0] push_data_i,
  input  logic              pop_i,
  output logic [s_addr-1:0] head_addr_o,
  output logic [s_line-1:0] head_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [cnt_w-1:0]  count_o,
  output logic [ptr_w-1:0]  rd_ptr_o,
  output logic [depth-1:0]  ent_valid_o,
  output logic [s_addr-1:0] ent_addr_o [depth],
  output logic [s_line-1:0] ent_data_o [depth]
);

  logic [s_addr-1:0] addr_mem_q [depth];
  logic [s_line-1:0] data_mem_q [depth];
  logic [ptr_w-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ptr_w-1:0]  wr_ptr_q, wr_ptr_d;
  logic [cnt_w-1:0]  count_q, count_d;
  logic [depth-1:0]  valid_q, valid_d;
  logic              push_ok_s, pop_ok_s;
  logic              full_s, empty_s;

  assign full_s  = (count_q == cnt_w'(depth));
  assign empty_s = (count_q == {cnt_w{1'b0}});

  // Next-state for pointers, occupancy and valid flags; a push into a full
  // FIFO or a pop from an empty one is dropped so count never leaves 0..depth.
  always_comb begin
    push_ok_s = push_i && !full_s;
    pop_ok_s  = pop_i && !empty_s;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    valid_d   = valid_q;
    if (pop_ok_s) begin
      rd_ptr_d          = rd_ptr_q + ptr_w'(1);
      valid_d[rd_ptr_q] = 1'b0;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_ok_s) begin
      wr_ptr_d          = wr_ptr_q + ptr_w'(1);
      valid_d[wr_ptr_q] = 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + cnt_w'(1);
      2'b01:   count_d = count_q - cnt_w'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer, occupancy and valid-flag registers; reset empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= {ptr_w{1'b0}};
      wr_ptr_q <= {ptr_w{1'b0}};
      count_q  <= {cnt_w{1'b0}};
      valid_q  <= {depth{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Line storage; contents only matter where the valid flag is set.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      addr_mem_q[wr_ptr_q] <= push_addr_i;
      data_mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_addr_o = addr_mem_q[rd_ptr_q];
  assign head_data_o = data_mem_q[rd_ptr_q];
  assign full_o      = full_s;
  assign empty_o     = empty_s;
  assign count_o     = count_q;
  assign rd_ptr_o    = rd_ptr_q;
  assign ent_valid_o = valid_q;
  assign ent_addr_o  = addr_mem_q;
  assign ent_data_o  = data_mem_q;

endmodule

// File: rtl/vc_wb_buffer.sv
// Victim-cache writeback buffer: queues dirty lines, drains them in order to
// physical memory, and optionally answers probes for still-pending lines.
// Build option: define VC_WB_LOOKUP_EN to include the probe comparators;
// without it the lookup ports remain and read back as zero.
module vc_wb_buffer
  import vc_types_pkg::*;
#(
  parameter int unsigned s_line = DEF_S_LINE,
  parameter int unsigned s_addr = DEF_S_ADDR,
  parameter int unsigned depth  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   evict_valid,
  output logic                   evict_ready,
  input  logic [s_addr-1:0]      evict_addr,
  input  logic [s_line-1:0]      evict_data,
  input  logic                   lookup_read,
  input  logic [s_addr-1:0]      lookup_addr,
  output logic                   lookup_hit,
  output logic [s_line-1:0]      lookup_data,
  output logic [s_addr-1:0]      pmem_address,
  output logic [s_line-1:0]      pmem_wdata,
  output logic                   pmem_write,
  input  logic                   pmem_resp,
  output logic [$clog2(depth):0] count,
  output logic                   empty
);

  localparam int unsigned ptr_w = $clog2(depth);

  wb_state_t         state_q, state_d;
  logic              push_s, pop_s;
  logic              fifo_full_s, fifo_empty_s;
  logic [s_addr-1:0] head_addr_s;
  logic [s_line-1:0] head_data_s;
  logic [ptr_w-1:0]  fifo_rd_ptr_s;
  logic [depth-1:0]  fifo_ent_valid_s;
  logic [s_addr-1:0] fifo_ent_addr_s [depth];
  logic [s_line-1:0] fifo_ent_data_s [depth];

  // Ready comes only from registered occupancy, so a full buffer refuses a
  // line even in the cycle its head is being retired.
  assign evict_ready = !rst && !fifo_full_s;
  assign push_s      = evict_valid && evict_ready;
  assign pop_s       = (state_q == WRITE) && pmem_resp;

  vc_wb_fifo #(
    .s_line (s_line),
    .s_addr (s_addr),
    .depth  (depth)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_s),
    .push_addr_i (evict_addr),
    .push_data_i (evict_data),
    .pop_i       (pop_s),
    .head_addr_o (head_addr_s),
    .head_data_o (head_data_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .count_o     (count),
    .rd_ptr_o    (fifo_rd_ptr_s),
    .ent_valid_o (fifo_ent_valid_s),
    .ent_addr_o  (fifo_ent_addr_s),
    .ent_data_o  (fifo_ent_data_s)
  );

  assign empty = fifo_empty_s;

  // Writeback state register; reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a line arriving into an empty buffer starts the write on the
  // very next cycle; each completion returns to IDLE for one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s || push_s) begin
          state_d = WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (pmem_resp) begin
          state_d = IDLE;
        end else begin
          state_d = WRITE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The head entry is stable while WRITE holds, since it only moves on pmem_resp.
  assign pmem_write   = (state_q == WRITE);
  assign pmem_address = pmem_write ? head_addr_s : {s_addr{1'b0}};
  assign pmem_wdata   = pmem_write ? head_data_s : {s_line{1'b0}};

`ifdef VC_WB_LOOKUP_EN
  logic              hit_q, hit_d;
  logic [s_line-1:0] data_q, data_d;
  logic [ptr_w-1:0]  lk_idx_s;

  // Probe all occupied slots oldest to newest so the youngest match wins;
  // uses the contents as they stand before the coming edge.
  always_comb begin
    hit_d    = 1'b0;
    data_d   = {s_line{1'b0}};
    lk_idx_s = fifo_rd_ptr_s;
    if (lookup_read) begin
      for (int unsigned k = 0; k < depth; k++) begin
        lk_idx_s = fifo_rd_ptr_s + ptr_w'(k);
        if (fifo_ent_valid_s[lk_idx_s] && (fifo_ent_addr_s[lk_idx_s] == lookup_addr)) begin
          hit_d  = 1'b1;
          data_d = fifo_ent_data_s[lk_idx_s];
        end else begin
          hit_d  = hit_d;
          data_d = data_d;
        end
      end
    end else begin
      hit_d  = 1'b0;
      data_d = {s_line{1'b0}};
    end
  end

  // Registered probe result, presented the cycle after lookup_read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q  <= 1'b0;
      data_q <= {s_line{1'b0}};
    end else begin
      hit_q  <= hit_d;
      data_q <= data_d;
    end
  end

  assign lookup_hit  = hit_q;
  assign lookup_data = data_q;
`else
  logic unused_lookup_s;

  // Probe path absent: fold the otherwise idle probe inputs into a sink.
  always_comb begin
    unused_lookup_s = lookup_read ^ (^lookup_addr) ^ (^fifo_rd_ptr_s) ^ (^fifo_ent_valid_s);
    for (int unsigned k = 0; k < depth; k++) begin
      unused_lookup_s = unused_lookup_s ^ (^fifo_ent_addr_s[k]) ^ (^fifo_ent_data_s[k]);
    end
  end

  assign lookup_hit  = 1'b0;
  assign lookup_data = {s_line{1'b0}};
`endif

endmodule

// File: tb/tb_vc_wb_buffer.sv
// Bench for vc_wb_buffer: directed scenarios plus random traffic, checked
// against a queue-based reference model and a writeback scoreboard.
module tb_vc_wb_buffer;

  localparam int DEPTH = 4;
  localparam int SL    = 256;
  localparam int SA    = 32;
`ifdef VC_WB_LOOKUP_EN
  localparam bit LK = 1'b1;
`else
  localparam bit LK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          evict_valid = 1'b0;
  logic          evict_ready;
  logic [SA-1:0] evict_addr = '0;
  logic [SL-1:0] evict_data = '0;
  logic          lookup_read = 1'b0;
  logic [SA-1:0] lookup_addr = '0;
  logic          lookup_hit;
  logic [SL-1:0] lookup_data;
  logic [SA-1:0] pmem_address;
  logic [SL-1:0] pmem_wdata;
  logic          pmem_write;
  logic          pmem_resp = 1'b0;
  logic [2:0]    count;
  logic          empty;

  vc_wb_buffer #(.s_line(SL), .s_addr(SA), .depth(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .evict_valid  (evict_valid),
    .evict_ready  (evict_ready),
    .evict_addr   (evict_addr),
    .evict_data   (evict_data),
    .lookup_read  (lookup_read),
    .lookup_addr  (lookup_addr),
    .lookup_hit   (lookup_hit),
    .lookup_data  (lookup_data),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_write   (pmem_write),
    .pmem_resp    (pmem_resp),
    .count        (count),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SA-1:0] a;
    logic [SL-1:0] d;
  } ent_t;

  int   errors = 0;
  int   checks = 0;
  int   hi_cnt = 0;
  ent_t m_q[$];     // lines the model says are buffered, oldest first
  ent_t wb_exp[$];  // writebacks still expected at memory, in order
  bit   m_writing = 1'b0;
  logic m_lk_hit = 1'b0;
  logic [SL-1:0] m_lk_data = '0;
  bit   m_pop, m_push, m_had;
  ent_t m_ent, sb_ent;

  task automatic chk(input string nm, input logic [SL-1:0] act, input logic [SL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a line is taken whenever fewer than DEPTH are held,
  // memory retires the oldest line when it answers a pending write, and a
  // write is pending whenever lines are held, except for the cycle after
  // a completion.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      wb_exp.delete();
      m_writing = 1'b0;
      m_lk_hit  = 1'b0;
      m_lk_data = '0;
    end else begin
      m_pop  = m_writing && pmem_resp;
      m_push = evict_valid && (m_q.size() < DEPTH);
      m_had  = (m_q.size() != 0);
      m_lk_hit  = 1'b0;
      m_lk_data = '0;
      if (LK && lookup_read) begin
        for (int i = m_q.size() - 1; i >= 0; i--) begin
          if (m_q[i].a == lookup_addr) begin
            m_lk_hit  = 1'b1;
            m_lk_data = m_q[i].d;
            break;
          end
        end
      end
      if (m_pop) void'(m_q.pop_front());
      if (m_push) begin
        m_ent.a = evict_addr;
        m_ent.d = evict_data;
        m_q.push_back(m_ent);
        wb_exp.push_back(m_ent);
      end
      m_writing = m_writing ? !m_pop : (m_had || m_push);
    end
  end

  // Monitor: mid-cycle comparison of all outputs; completed writebacks are
  // popped from the scoreboard and checked in order.
  always @(negedge clk) begin
    chk("evict_ready", evict_ready, !rst && (m_q.size() < DEPTH));
    chk("count", count, m_q.size());
    chk("empty", empty, m_q.size() == 0);
    chk("pmem_write", pmem_write, m_writing);
    chk("lookup_hit", lookup_hit, m_lk_hit);
    chk("lookup_data", lookup_data, m_lk_data);
    if (pmem_write) hi_cnt++;
    if (m_writing && m_q.size() > 0) begin
      chk("pmem_address_head", pmem_address, m_q[0].a);
      chk("pmem_wdata_head", pmem_wdata, m_q[0].d);
    end
    if (!rst && pmem_write && pmem_resp) begin
      if (wb_exp.size() == 0) begin
        chk("wb_unexpected", 1'b1, 1'b0);
      end else begin
        sb_ent = wb_exp.pop_front();
        chk("wb_addr", pmem_address, sb_ent.a);
        chk("wb_data", pmem_wdata, sb_ent.d);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic evict(input logic [SA-1:0] a, input logic [SL-1:0] d);
    logic acc;
    acc = 1'b0;
    evict_valid = 1'b1;
    evict_addr  = a;
    evict_data  = d;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      acc = evict_ready;
      cyc();
      if (acc) break;
    end
    chk("evict_accept", acc, 1'b1);
    evict_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    pmem_resp = 1'b1;
    for (int n = 0; n < 100; n++) begin
      cyc();
      if (m_q.size() == 0 && !m_writing) begin
        done = 1'b1;
        break;
      end
    end
    pmem_resp = 1'b0;
    chk("drain_done", done, 1'b1);
  endtask

  function automatic logic [SL-1:0] rnd_line();
    logic [SL-1:0] v;
    for (int i = 0; i < SL / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  logic [SL-1:0] d1, d2, d3;
  int h0;

  initial begin
    // Power-on reset.
    #1 rst = 1'b1;
    cyc(); cyc(); cyc();
    rst = 1'b0;
    cyc();

    // Single line, memory answers on the fourth write cycle.
    h0 = hi_cnt;
    evict(32'h0000_0100, {8{32'hA5A5_A5A5}});
    cyc(); cyc(); cyc();
    pmem_resp = 1'b1;
    cyc();
    pmem_resp = 1'b0;
    chk("single_write_cycles", hi_cnt - h0, 4);
    chk("single_empty_after", empty, 1'b1);
    cyc();

    // Fill to DEPTH, fifth line waits for the first completion.
    for (int i = 0; i < 4; i++) evict(32'h1000 + i * 32'h40, rnd_line());
    chk("full_count", count, 3'd4);
    chk("full_ready", evict_ready, 1'b0);
    fork
      evict(32'h2000, rnd_line());
      begin
        cyc(); cyc(); cyc();
        pmem_resp = 1'b1;
        cyc();
        pmem_resp = 1'b0;
      end
    join
    drain();

    // Two lines to the same address: the youngest one answers the probe.
    d1 = rnd_line();
    d2 = rnd_line();
    evict(32'h0000_0200, d1);
    evict(32'h0000_0200, d2);
    lookup_read = 1'b1;
    lookup_addr = 32'h0000_0200;
    cyc();
    lookup_read = 1'b0;
    chk("dup_lookup_hit", lookup_hit, LK);
    chk("dup_lookup_data", lookup_data, LK ? d2 : '0);
    drain();

    // Probe in the same cycle the line retires sees it; the next probe does not.
    d3 = rnd_line();
    evict(32'h0000_0300, d3);
    lookup_read = 1'b1;
    lookup_addr = 32'h0000_0300;
    pmem_resp   = 1'b1;
    cyc();
    pmem_resp = 1'b0;
    chk("pop_lookup_hit", lookup_hit, LK);
    chk("pop_lookup_data", lookup_data, LK ? d3 : '0);
    cyc();
    lookup_read = 1'b0;
    chk("after_pop_lookup_hit", lookup_hit, 1'b0);
    cyc();

    // Reset in the middle of a write with three lines held.
    for (int i = 0; i < 3; i++) evict(32'h3000 + i * 32'h40, rnd_line());
    #2 rst = 1'b1;
    #1;
    chk("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_ready", evict_ready, 1'b0);
    chk("rst_pmem_address", pmem_address, '0);
    chk("rst_pmem_wdata", pmem_wdata, '0);
    cyc(); cyc();
    rst = 1'b0;
    pmem_resp = 1'b1;
    cyc(); cyc(); cyc();
    pmem_resp = 1'b0;
    chk("stray_resp_count", count, 3'd0);
    chk("stray_resp_write", pmem_write, 1'b0);

    // Random traffic over a small address set so probes often hit.
    for (int n = 0; n < 600; n++) begin
      evict_valid = ($urandom % 2) == 0;
      evict_addr  = {24'h0, 4'($urandom_range(0, 7)), 4'h0};
      evict_data  = rnd_line();
      lookup_read = ($urandom % 2) == 0;
      lookup_addr = {24'h0, 4'($urandom_range(0, 7)), 4'h0};
      pmem_resp   = ($urandom % 3) == 0;
      cyc();
    end
    evict_valid = 1'b0;
    lookup_read = 1'b0;
    drain();
    cyc();
    chk("scoreboard_empty", wb_exp.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
